// File: rtl/prbs_pkg.sv
// prbs_pkg: PRBS16 polynomial constants, checker state encoding and next-bit function
// shared by the PRBS16 generator and checker.
package prbs_pkg;
    localparam int PRBS_W = 16;
    localparam int TAP_A = 15;
    localparam int TAP_B = 14;
    localparam int TAP_C = 12;
    localparam int TAP_D = 3;

    typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_e;

    function automatic logic prbs_next(input logic [PRBS_W-1:0] r);
        return r[TAP_A] ^ r[TAP_B] ^ r[TAP_C] ^ r[TAP_D];
    endfunction
endpackage

// File: rtl/prbs16_checker.sv
// prbs16_checker: self-synchronising PRBS16 receiver with lock detection,
// windowed loss-of-lock and saturating error/bit counters.
module prbs16_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_LEN  = 32,
    parameter int WINDOW    = 256,
    parameter int ERR_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        bit_in,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err,
    output logic [15:0] err_count,
    output logic [31:0] bits_checked
);
    localparam int RW = $clog2(LOCK_LEN + 1);
    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam logic [RW-1:0] RUN_LAST = RW'(LOCK_LEN - 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
    localparam logic [EW-1:0] ERR_MAX  = EW'(ERR_LIMIT);

    state_e              state_q, state_d;
    logic [PRBS_W-1:0]   r_q, r_d;
    logic [3:0]          fill_q, fill_d;
    logic [RW-1:0]       run_q, run_d;
    logic [WW-1:0]       wbit_q, wbit_d;
    logic [EW-1:0]       werr_q, werr_d;
    logic                err_q, err_d;
    logic [15:0]         err_count_q, err_count_d;
    logic [31:0]         bits_q, bits_d;

    logic          exp_bit, mism, wrap;
    logic [EW-1:0] werr_inc;

    assign exp_bit  = prbs_next(r_q);
    assign mism     = bit_in ^ exp_bit;
    assign wrap     = wbit_q == WIN_LAST;
    assign werr_inc = werr_q + EW'(mism);

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        fill_d      = fill_q;
        run_d       = run_q;
        wbit_d      = wbit_q;
        werr_d      = werr_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        bits_d      = bits_q;
        if (en) begin
            case (state_q)
                SEED: begin
                    r_d    = {r_q[PRBS_W-2:0], bit_in};
                    fill_d = fill_q + 4'd1;
                    if (fill_q == 4'd15) begin
                        state_d = VERIFY;
                        run_d   = '0;
                    end
                end
                VERIFY: begin
                    // An all-zero register would predict zeros forever; force a reseed.
                    if (r_q == '0 || mism) begin
                        state_d = SEED;
                        fill_d  = '0;
                    end else begin
                        r_d   = {r_q[PRBS_W-2:0], bit_in};
                        run_d = run_q + RW'(1);
                        if (run_q == RUN_LAST) begin
                            state_d = LOCKED;
                            wbit_d  = '0;
                            werr_d  = '0;
                        end
                    end
                end
                LOCKED: begin
                    r_d         = {r_q[PRBS_W-2:0], exp_bit};
                    bits_d      = &bits_q ? bits_q : bits_q + 32'd1;
                    err_d       = mism;
                    err_count_d = (mism && !(&err_count_q)) ? err_count_q + 16'd1 : err_count_q;
                    wbit_d      = wrap ? '0 : wbit_q + WW'(1);
                    werr_d      = wrap ? '0 : werr_inc;
                    if (werr_inc == ERR_MAX) begin
                        state_d = SEED;
                        fill_d  = '0;
                    end
                end
                default: state_d = SEED;
            endcase
        end
        if (clr_cnt) begin
            err_count_d = '0;
            bits_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEED;
            r_q         <= '0;
            fill_q      <= '0;
            run_q       <= '0;
            wbit_q      <= '0;
            werr_q      <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            bits_q      <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            fill_q      <= fill_d;
            run_q       <= run_d;
            wbit_q      <= wbit_d;
            werr_q      <= werr_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            bits_q      <= bits_d;
        end
    end

    assign locked       = state_q == LOCKED;
    assign err          = err_q;
    assign err_count    = err_count_q;
    assign bits_checked = bits_q;
endmodule

// File: tb/tb_prbs16_checker.sv
// tb_prbs16_checker: directed and randomized checks of prbs16_checker against a
// stream-level reference model driven by a recurrence-generated PRBS16 sequence.
module tb_prbs16_checker;
    localparam int LOCK_LEN  = 32;
    localparam int WINDOW    = 256;
    localparam int ERR_LIMIT = 8;
    localparam int NS        = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        bit_in = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        locked;
    logic        err;
    logic [15:0] err_count;
    logic [31:0] bits_checked;

    prbs16_checker #(.LOCK_LEN(LOCK_LEN), .WINDOW(WINDOW), .ERR_LIMIT(ERR_LIMIT)) dut (
        .clk(clk), .rst(rst), .en(en), .bit_in(bit_in), .clr_cnt(clr_cnt),
        .locked(locked), .err(err), .err_count(err_count), .bits_checked(bits_checked)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // s[k+16] is the k-th transmitted bit; s[0..15] is the all-ones generator seed.
    bit s [0:NS+15];
    int sp = 0;

    // Reference model: mode 0 = seeding, 1 = verifying, 2 = locked.
    int          mode, fill, run, wbits, werr;
    int unsigned m_ecnt, m_bchk;
    bit          m_err;
    bit          hist[$];
    int          npulse = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_hist(input bit v);
        hist.push_back(v);
        void'(hist.pop_front());
    endtask

    task automatic model_step(input logic e, input logic b, input logic c, input logic r);
        bit x;
        bit z;
        if (r) begin
            mode = 0; fill = 0; run = 0; wbits = 0; werr = 0;
            m_ecnt = 0; m_bchk = 0; m_err = 0;
            hist.delete();
            repeat (16) hist.push_back(1'b0);
        end else begin
            m_err = 0;
            if (e) begin
                x = hist[0] ^ hist[1] ^ hist[3] ^ hist[12];
                if (mode == 0) begin
                    push_hist(b);
                    fill++;
                    if (fill == 16) begin mode = 1; run = 0; end
                end else if (mode == 1) begin
                    z = 1;
                    foreach (hist[i]) if (hist[i]) z = 0;
                    if (z || b != x) begin
                        mode = 0; fill = 0;
                    end else begin
                        push_hist(b);
                        run++;
                        if (run == LOCK_LEN) begin mode = 2; wbits = 0; werr = 0; end
                    end
                end else begin
                    push_hist(x);
                    if (m_bchk != 32'hFFFF_FFFF) m_bchk++;
                    if (b != x) begin
                        m_err = 1;
                        if (m_ecnt != 16'hFFFF) m_ecnt++;
                        werr++;
                    end
                    if (werr >= ERR_LIMIT) begin
                        mode = 0; fill = 0;
                    end else begin
                        wbits++;
                        if (wbits == WINDOW) begin wbits = 0; werr = 0; end
                    end
                end
            end
            if (c) begin m_ecnt = 0; m_bchk = 0; end
        end
    endtask

    task automatic tick(input logic e, input logic b, input logic c, input logic r);
        en = e; bit_in = b; clr_cnt = c; rst = r;
        @(posedge clk);
        #1;
        model_step(e, b, c, r);
        chk("locked", 32'(locked), 32'(mode == 2));
        chk("err", 32'(err), 32'(m_err));
        chk("err_count", 32'(err_count), m_ecnt);
        chk("bits_checked", bits_checked, m_bchk);
        if (err === 1'b1) npulse++;
    endtask

    task automatic send(input bit flip, input bit c);
        tick(1'b1, s[sp+16] ^ flip, c, 1'b0);
        sp++;
    endtask

    task automatic idle();
        tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    endtask

    int  acc;
    int  k;
    bit  ever_locked;

    initial begin
        for (int i = 0; i < 16; i++) s[i] = 1'b1;
        for (int i = 16; i < NS + 16; i++) s[i] = s[i-16] ^ s[i-15] ^ s[i-13] ^ s[i-4];

        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_bits", bits_checked, 32'd0);

        // Clean generator stream: lock after 48 bits, then one flipped bit at index 200.
        npulse = 0;
        repeat (47) send(1'b0, 1'b0);
        chk("lock_47", 32'(locked), 32'd0);
        send(1'b0, 1'b0);
        chk("lock_48", 32'(locked), 32'd1);
        chk("lock_err_count", 32'(err_count), 32'd0);
        while (sp < 300) send(sp == 200, 1'b0);
        chk("flip_pulses", 32'(npulse), 32'd1);
        chk("flip_err_count", 32'(err_count), 32'd1);
        chk("flip_locked", 32'(locked), 32'd1);
        chk("flip_bits", bits_checked, 32'd252);

        // Eight errors in 71 bits inside one window drop lock; clean stream relocks in 48.
        send(1'b0, 1'b1);
        chk("clr_err_count", 32'(err_count), 32'd0);
        while (sp < 310) send(1'b0, 1'b0);
        for (k = 0; k < 71; k++) begin
            send(k % 10 == 0, 1'b0);
            if (k == 60) chk("burst_7_locked", 32'(locked), 32'd1);
        end
        chk("burst_8_locked", 32'(locked), 32'd0);
        chk("burst_err_count", 32'(err_count), 32'd8);
        repeat (47) send(1'b0, 1'b0);
        chk("relock_47", 32'(locked), 32'd0);
        send(1'b0, 1'b0);
        chk("relock_48", 32'(locked), 32'd1);
        chk("relock_err_count", 32'(err_count), 32'd8);

        // clr_cnt coincident with an erroneous bit wins over the increment.
        send(1'b1, 1'b1);
        chk("clr_err_pulse", 32'(err), 32'd1);
        chk("clr_err_cnt0", 32'(err_count), 32'd0);
        repeat (20) send(1'b0, 1'b0);
        chk("clr_clean_cnt", 32'(err_count), 32'd0);
        chk("clr_clean_locked", 32'(locked), 32'd1);

        // Reset while locked overrides en and clr_cnt.
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_bits", bits_checked, 32'd0);

        // Random en, occasional bit flips and counter clears, checked cycle by cycle.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 1) == 1) send($urandom_range(0, 99) < 3, $urandom_range(0, 49) == 0);
            else idle();
        end

        // Constant zero input never locks.
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        ever_locked = 0;
        repeat (1000) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0);
            if (locked === 1'b1) ever_locked = 1;
        end
        chk("zero_never_locked", 32'(ever_locked), 32'd0);
        chk("zero_err_count", 32'(err_count), 32'd0);

        // Random en with clean stream: lock after exactly 48 accepted bits.
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        acc = 0;
        for (int i = 0; i < 600 && locked !== 1'b1; i++) begin
            if ($urandom_range(0, 1) == 1) begin send(1'b0, 1'b0); acc++; end
            else idle();
        end
        chk("rand_lock_acc", 32'(acc), 32'd48);
        acc = 0;
        repeat (300) begin
            if ($urandom_range(0, 1) == 1) begin send(1'b0, 1'b0); acc++; end
            else idle();
        end
        chk("rand_bits_checked", bits_checked, 32'(acc));
        chk("rand_err_count", 32'(err_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prbs16_checker.md
PRBS16_CHECKER -- requirements
Module: prbs16_checker

Interface
REQ-001 Parameter LOCK_LEN, default 32: consecutive correct bits required in VERIFY before lock.
REQ-002 Parameter WINDOW, default 256: length in accepted bits of the loss-of-lock error window.
REQ-003 Parameter ERR_LIMIT, default 8: errors within one window that force loss of lock.
REQ-004 Clock and reset: clock clk; reset rst, synchronous, active-high.
REQ-005 Port clk, input, 1: clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1: synchronous active-high reset.
REQ-007 Port en, input, 1: bit_in is valid this cycle; driven from the same enable as the upstream PRBS16 generator.
REQ-008 Port bit_in, input, 1: received serial bit, i.e. generator data_out[0].
REQ-009 Port clr_cnt, input, 1: synchronous clear of err_count and bits_checked only.
REQ-010 Port locked, output, 1: checker is in state LOCKED.
REQ-011 Port err, output, 1: one-cycle pulse per mismatched bit while LOCKED.
REQ-012 Port err_count, output, 16: saturating count of LOCKED-state errors.
REQ-013 Port bits_checked, output, 32: saturating count of bits compared while LOCKED.

Function
REQ-014 The checker holds a 16-bit register r; expected bit = r[15]^r[14]^r[12]^r[3], computed from r before the shift; a shift is {r[14:0], b}.
REQ-015 With en low, all state, counters and r hold, and err is 0.
REQ-016 SEED state: each en shifts bit_in into r and increments fill count; after the 16th bit, go to VERIFY with the run count cleared.
REQ-017 VERIFY, match: shift bit_in into r and increment the run count; on reaching LOCK_LEN, go to LOCKED with window bit count and window error count cleared.
REQ-018 VERIFY, mismatch: go to SEED with fill count 0; err is not pulsed and counters are unchanged.
REQ-019 VERIFY with r == 16'h0000 (all-zero lockup state): go to SEED regardless of bit_in, so constant-zero input never locks.
REQ-020 LOCKED: shift the expected bit, not bit_in, into r (free-running reference); increment bits_checked, saturating at 32'hFFFF_FFFF.
REQ-021 LOCKED, mismatch: err=1 on the next cycle; err_count +1 saturating at 16'hFFFF; window error count +1.
REQ-022 LOCKED window: the window bit count wraps WINDOW-1 -> 0, and the window error count clears on wrap.
REQ-023 When the window error count reaches ERR_LIMIT (including via the mismatch on the wrap bit), go to SEED and deassert locked.
REQ-024 clr_cnt has priority over a simultaneous increment: err_count and bits_checked become 0 that cycle; state, r and window counters are unaffected.
REQ-025 locked and err are registered outputs, with no combinational path from inputs; locked rises the cycle after the accepted bit that completes LOCK_LEN.

Reset
REQ-026 On rst: state=SEED, r=0, fill/run/window counters=0, locked=0, err=0, err_count=0, bits_checked=0.
REQ-027 rst mid-operation, including while LOCKED, overrides en and clr_cnt and takes effect on the same edge.

Structure
REQ-028 Shared package prbs_pkg holds the state enum (SEED, VERIFY, LOCKED), the PRBS16 tap constants (15, 14, 12, 3), the width constant 16, and a next-bit function shared with the generator.
REQ-029 No sub-module is required; the block is a single module with one state register and counters.

Verification
REQ-030 Generator (SEED=16'hFFFF) feeding the checker with en=1 continuously: locked=1 after 48 en cycles, err_count=0, first received bit=0.
REQ-031 Flip the single bit at index 200 of the stream: exactly one err pulse, err_count=1, locked stays 1, no further errors.
REQ-032 Flip 8 bits within 100 bits while locked: locked drops after the 8th error; with a clean stream afterwards, locked returns after 48 more en cycles; err_count=8.
REQ-033 Constant bit_in=0 for 1000 cycles: locked stays 0 and err_count=0.
REQ-034 clr_cnt pulsed in the same cycle as an error pulse-causing bit: err_count=0 next cycle; clean continuation leaves err_count=0.
REQ-035 Toggle en randomly (50%) with a clean stream: lock is reached after exactly 48 accepted bits, and bits_checked equals the number of accepted bits after lock.
